vram_bus_sched: RTL and testbench



---
 rtl/vram_bus_sched.sv | 165 ++++++++++++++++
 tb/tb_vram_bus_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_bus_sched.sv
// PPU external VRAM bus sequencer: arbitrates render fetch vs CPU $2007, drives ALE/RD/WR phases (optional VRAM_PAL_DECODE_EN diverts $3Fxx CPU writes to pal_wr).
// Latency: request seen at an IDLE/DATA edge -> ADDR (ack) next cycle, DATA after, read valid one cycle after DATA.
// Backpressure: requesters hold req until their ack pulse; one access in flight, starvation counter bounds CPU wait.
module vram_bus_sched #(
    parameter int STARVE_MAX = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        blnk,
    input  logic        render_req,
    input  logic [13:0] render_addr,
    output logic        render_ack,
    output logic        render_valid,
    output logic [7:0]  render_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_valid,
    output logic [7:0]  cpu_rdata,
    input  logic [7:0]  pd_in,
    output logic [13:0] pa_out,
    output logic        ale,
    output logic        rd,
    output logic        wr,
    output logic        ad_oe,
    output logic [7:0]  ad_wdata,
    output logic        pal_wr,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic       own_cpu;
    logic       op_we;
    logic       grant_vld;
    logic       grant_cpu;
    logic       render_elig;
    logic       starve_hit;
    logic       rd_done;
    logic       pal_sel;
    logic [7:0] starve_cnt;

    assign render_elig = render_req & ~blnk;
    assign starve_hit  = (starve_cnt >= STARVE_LIM);
    assign rd_done     = (state == ST_DATA) & ~op_we;

    // Grants are only evaluated when the bus is free: at the end of IDLE or DATA.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_cpu = 1'b0;
        case (state)
            ST_ADDR: state_nxt = ST_DATA;
            default: begin
                if (render_elig | cpu_req) begin
                    state_nxt = ST_ADDR;
                    grant_vld = 1'b1;
                    grant_cpu = cpu_req & (starve_hit | ~render_elig);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef VRAM_PAL_DECODE_EN
    assign pal_sel = op_we & (pa_out[13:8] == 6'h3F);

    always_ff @(posedge CLK) begin
        if (RES) begin
            pal_wr <= 1'b0;
        end else begin
            pal_wr <= (state == ST_ADDR) & pal_sel;
        end
    end
`else
    assign pal_sel = 1'b0;
    assign pal_wr  = 1'b0;
`endif

    // Owner/op and the bus address are latched at grant and held through DATA.
    always_ff @(posedge CLK) begin
        if (RES) begin
            own_cpu  <= 1'b0;
            op_we    <= 1'b0;
            pa_out   <= 14'd0;
            ad_wdata <= 8'd0;
        end else if (grant_vld) begin
            own_cpu <= grant_cpu;
            op_we   <= grant_cpu & cpu_we;
            pa_out  <= grant_cpu ? cpu_addr : render_addr;
            if (grant_cpu) begin
                ad_wdata <= cpu_wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            ale        <= 1'b0;
            render_ack <= 1'b0;
            cpu_ack    <= 1'b0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            ad_oe      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ale        <= grant_vld;
            render_ack <= grant_vld & ~grant_cpu;
            cpu_ack    <= grant_vld & grant_cpu;
            rd         <= (state == ST_ADDR) & ~op_we;
            wr         <= (state == ST_ADDR) & op_we & ~pal_sel;
            ad_oe      <= (state == ST_ADDR) & op_we & ~pal_sel;
            busy       <= (state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            render_valid <= 1'b0;
            cpu_valid    <= 1'b0;
            render_data  <= 8'd0;
            cpu_rdata    <= 8'd0;
        end else begin
            render_valid <= rd_done & ~own_cpu;
            cpu_valid    <= rd_done & own_cpu;
            if (rd_done & ~own_cpu) begin
                render_data <= pd_in;
            end
            if (rd_done & own_cpu) begin
                cpu_rdata <= pd_in;
            end
        end
    end

    // Counts cycles the CPU has been waiting; the ack cycle itself restarts it.
    always_ff @(posedge CLK) begin
        if (RES) begin
            starve_cnt <= 8'd0;
        end else if (!cpu_req || cpu_ack) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vram_bus_sched.sv
// Bench for vram_bus_sched: transaction-timestamp model compared every cycle, plus directed literal checks.
module tb_vram_bus_sched;

    localparam int SM = 4;

    logic        CLK = 1'b0;
    logic        RES;
    logic        blnk;
    logic        render_req;
    logic [13:0] render_addr;
    logic        render_ack;
    logic        render_valid;
    logic [7:0]  render_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        cpu_valid;
    logic [7:0]  cpu_rdata;
    logic [7:0]  pd_in;
    logic [13:0] pa_out;
    logic        ale;
    logic        rd;
    logic        wr;
    logic        ad_oe;
    logic [7:0]  ad_wdata;
    logic        pal_wr;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    vram_bus_sched #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .RES(RES), .blnk(blnk),
        .render_req(render_req), .render_addr(render_addr), .render_ack(render_ack),
        .render_valid(render_valid), .render_data(render_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .pd_in(pd_in), .pa_out(pa_out), .ale(ale), .rd(rd), .wr(wr),
        .ad_oe(ad_oe), .ad_wdata(ad_wdata), .pal_wr(pal_wr), .busy(busy)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 'h%0h want 'h%0h", nm, $time, got, exp);
        end
    endtask

    // Model: one access record stamped with the cycle of its ADDR phase.
    int          cyc = 0;
    bit          a_act = 1'b0;
    bit          a_cpu;
    bit          a_we;
    logic [13:0] a_addr;
    int          a_t0;
    int          wait_n;
    logic [13:0] m_pa;
    logic [7:0]  m_wd;
    logic [7:0]  m_rdat_r;
    logic [7:0]  m_rdat_c;
    bit          m_rv;
    bit          m_cv;

    always @(posedge CLK) begin
        bit in_a;
        bit in_d;
        bit ack_c;
        bit r_el;
        if (RES) begin
            a_act = 1'b0; wait_n = 0; m_pa = '0; m_wd = '0;
            m_rdat_r = '0; m_rdat_c = '0; m_rv = 1'b0; m_cv = 1'b0;
        end else begin
            in_a  = a_act && (cyc == a_t0);
            in_d  = a_act && (cyc == a_t0 + 1);
            ack_c = in_a && a_cpu;
            m_rv  = in_d && !a_we && !a_cpu;
            m_cv  = in_d && !a_we && a_cpu;
            if (m_rv) m_rdat_r = pd_in;
            if (m_cv) m_rdat_c = pd_in;
            r_el = render_req && !blnk;
            if (!a_act || in_d) begin
                if (cpu_req && (wait_n >= SM || !r_el)) begin
                    a_act = 1'b1; a_cpu = 1'b1; a_we = cpu_we; a_addr = cpu_addr;
                    a_t0 = cyc + 1; m_pa = cpu_addr; m_wd = cpu_wdata;
                end else if (r_el) begin
                    a_act = 1'b1; a_cpu = 1'b0; a_we = 1'b0; a_addr = render_addr;
                    a_t0 = cyc + 1; m_pa = render_addr;
                end else begin
                    a_act = 1'b0;
                end
            end
            if (!cpu_req || ack_c) wait_n = 0;
            else if (wait_n < 255) wait_n++;
        end
        cyc++;
    end

    always @(negedge CLK) begin
        bit ph_a;
        bit ph_d;
        bit e_pal;
        bit e_wr;
        if (cyc > 0) begin
            ph_a = a_act && (cyc == a_t0);
            ph_d = a_act && (cyc == a_t0 + 1);
`ifdef VRAM_PAL_DECODE_EN
            e_pal = ph_d && a_we && (a_addr[13:8] == 6'h3F);
`else
            e_pal = 1'b0;
`endif
            e_wr = ph_d && a_we && !e_pal;
            chk("ale", ale, ph_a);
            chk("render_ack", render_ack, ph_a && !a_cpu);
            chk("cpu_ack", cpu_ack, ph_a && a_cpu);
            chk("rd", rd, ph_d && !a_we);
            chk("wr", wr, e_wr);
            chk("ad_oe", ad_oe, e_wr);
            chk("pal_wr", pal_wr, e_pal);
            chk("busy", busy, ph_a || ph_d);
            chk("pa_out", pa_out, m_pa);
            chk("render_valid", render_valid, m_rv);
            chk("cpu_valid", cpu_valid, m_cv);
            chk("render_data", render_data, m_rdat_r);
            chk("cpu_rdata", cpu_rdata, m_rdat_c);
            if (e_wr) chk("ad_wdata", ad_wdata, m_wd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    initial begin
        int ack_cyc;
        int n_r;
        RES = 1'b1; blnk = 1'b0; render_req = 1'b0; render_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; pd_in = '0;
        step(2);
        RES = 1'b0;
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_pa", pa_out, 0);
        step(1);

        // CPU write while rendering is blanked
        blnk = 1'b1; render_req = 1'b1; render_addr = 14'h0777;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2345; cpu_wdata = 8'h5A;
        step(1);
        chk("lit_w_ack", cpu_ack, 1);
        chk("lit_w_ale", ale, 1);
        chk("lit_w_pa", pa_out, 14'h2345);
        chk("lit_w_rack", render_ack, 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step(1);
        chk("lit_w_wr", wr, 1);
        chk("lit_w_oe", ad_oe, 1);
        chk("lit_w_wdata", ad_wdata, 8'h5A);
        render_req = 1'b0; blnk = 1'b0;
        step(1);
        chk("lit_w_idle", busy, 0);

        // Render read, blank rises mid-access
        render_req = 1'b1; render_addr = 14'h1010;
        step(1);
        chk("lit_r_ack", render_ack, 1);
        chk("lit_r_pa", pa_out, 14'h1010);
        render_req = 1'b0; blnk = 1'b1;
        step(1);
        chk("lit_r_rd", rd, 1);
        pd_in = 8'hC3;
        step(1);
        chk("lit_r_valid", render_valid, 1);
        chk("lit_r_data", render_data, 8'hC3);
        pd_in = 8'h00; blnk = 1'b0;
        step(1);
        chk("lit_r_pulse", render_valid, 0);
        chk("lit_r_hold", render_data, 8'hC3);

        // Starvation: render held continuously, CPU waits
        render_req = 1'b1; render_addr = 14'h0200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0400;
        ack_cyc = -1; n_r = 0;
        for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
            step(1);
            if (render_ack) n_r++;
            if (cpu_ack) begin
                ack_cyc = k;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("lit_starve_ack_cycle", ack_cyc, 5);
        chk("lit_starve_render_grants", n_r, 2);
        step(1);
        pd_in = 8'h3C;
        step(1);
        chk("lit_starve_resume", render_ack, 1);
        chk("lit_starve_cpu_valid", cpu_valid, 1);
        chk("lit_starve_cpu_data", cpu_rdata, 8'h3C);
        render_req = 1'b0; pd_in = 8'h00;
        step(3);

        // Back-to-back CPU reads
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0000;
        step(1);
        chk("lit_bb_ack0", cpu_ack, 1);
        cpu_addr = 14'h0001;
        step(1);
        pd_in = 8'h11;
        chk("lit_bb_busy", busy, 1);
        step(1);
        chk("lit_bb_ack1", cpu_ack, 1);
        chk("lit_bb_pa1", pa_out, 14'h0001);
        chk("lit_bb_valid0", cpu_valid, 1);
        chk("lit_bb_data0", cpu_rdata, 8'h11);
        cpu_req = 1'b0; pd_in = 8'h00;
        step(1);
        pd_in = 8'h22;
        chk("lit_bb_gap", cpu_valid, 0);
        step(1);
        chk("lit_bb_valid1", cpu_valid, 1);
        chk("lit_bb_data1", cpu_rdata, 8'h22);
        pd_in = 8'h00;

        // Palette-range CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3F01; cpu_wdata = 8'h77;
        step(1);
        chk("lit_pal_ale", ale, 1);
        chk("lit_pal_pa", pa_out, 14'h3F01);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step(1);
`ifdef VRAM_PAL_DECODE_EN
        chk("lit_pal_pulse", pal_wr, 1);
        chk("lit_pal_wr", wr, 0);
        chk("lit_pal_oe", ad_oe, 0);
`else
        chk("lit_pal_pulse", pal_wr, 0);
        chk("lit_pal_wr", wr, 1);
        chk("lit_pal_wdata", ad_wdata, 8'h77);
`endif
        step(1);

        // Reset asserted during DATA of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        step(1);
        cpu_req = 1'b0;
        step(1);
        RES = 1'b1; pd_in = 8'hAA;
        step(2);
        RES = 1'b0;
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_rd", rd, 0);
        chk("lit_rst_pa", pa_out, 0);
        chk("lit_rst_valid", cpu_valid, 0);
        chk("lit_rst_rdata", cpu_rdata, 0);
        chk("lit_rst_rdata_r", render_data, 0);
        pd_in = 8'h00;
        step(1);
        chk("lit_rst_no_valid", cpu_valid, 0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
